// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: configurable data width, parity and stop bits,
// valid/ready input handshake, LSB-first serialisation at F/BAUD clocks per bit.
module uart_tx_param #(
    parameter int unsigned F         = 50000000,
    parameter int unsigned BAUD      = 115200,
    parameter int unsigned DATA_BITS = 8,
    parameter int unsigned PARITY    = 0,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 tx,
    output logic                 busy
);

    localparam int unsigned DIV   = F / BAUD;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    // Reject configurations the datapath cannot represent
    if (DIV < 2) begin : g_div_check
        $error("uart_tx_param: F/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bits_check
        $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_par_check
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        PAR   = 3'd3,
        STOP  = 3'd4
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     idx_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_nxt;
    logic                 par_bit;
    logic                 par_bit_nxt;
    logic                 tx_nxt;
    logic                 ready_nxt;
    logic                 busy_nxt;
    logic                 bit_end;

    // State, datapath and registered line/handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            idx     <= idx_nxt;
            shreg   <= shreg_nxt;
            par_bit <= par_bit_nxt;
            tx      <= tx_nxt;
            ready   <= ready_nxt;
            busy    <= busy_nxt;
        end
    end

    // Next-state, bit timing and output decode of the upcoming state
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        idx_nxt     = idx;
        shreg_nxt   = shreg;
        par_bit_nxt = par_bit;
        tx_nxt      = 1'b1;
        ready_nxt   = 1'b0;
        busy_nxt    = 1'b1;

        bit_end = (cnt == CNT_W'(DIV - 1));

        if (state != IDLE) begin
            cnt_nxt = bit_end ? '0 : CNT_W'(cnt + 1'b1);
        end

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (valid && ready) begin
                    shreg_nxt   = data;
                    par_bit_nxt = (PARITY == 1) ? ~(^data) : (^data);
                    idx_nxt     = '0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    idx_nxt   = '0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_nxt = {1'b0, shreg[DATA_BITS-1:1]};
                    if (idx == IDX_W'(DATA_BITS - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_nxt = IDX_W'(idx + 1'b1);
                    end
                end
            end
            PAR: begin
                if (bit_end) begin
                    idx_nxt   = '0;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (idx == IDX_W'(STOP_BITS - 1)) begin
                        idx_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        idx_nxt = IDX_W'(idx + 1'b1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                idx_nxt   = '0;
            end
        endcase

        case (state_nxt)
            IDLE:    tx_nxt = 1'b1;
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            PAR:     tx_nxt = par_bit_nxt;
            STOP:    tx_nxt = 1'b1;
            default: tx_nxt = 1'b1;
        endcase

        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2)
// at DIV=10, table-driven frames plus back-to-back and mid-frame reset sequences.
module tb_uart_tx_param;

    localparam int DIV = 10;

    logic       clk;
    logic       rst;
    logic [3:0] valid_w;
    logic [3:0] ready_w;
    logic [3:0] tx_w;
    logic [3:0] busy_w;
    logic [7:0] d_8n1;
    logic [7:0] d_8e1;
    logic [7:0] d_8o1;
    logic [6:0] d_7n2;

    int checks;
    int failures;

    uart_tx_param #(.F(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .data(d_8n1), .valid(valid_w[0]),
        .ready(ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]));

    uart_tx_param #(.F(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .data(d_8e1), .valid(valid_w[1]),
        .ready(ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]));

    uart_tx_param #(.F(1000000), .BAUD(100000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .data(d_8o1), .valid(valid_w[2]),
        .ready(ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]));

    uart_tx_param #(.F(1000000), .BAUD(100000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .data(d_7n2), .valid(valid_w[3]),
        .ready(ready_w[3]), .tx(tx_w[3]), .busy(busy_w[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [8:0]  word;
        logic [15:0] frame;
        int          nbits;
        int          len;
        string       name;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic set_data(input int idx, input logic [8:0] v);
        case (idx)
            0: d_8n1 = v[7:0];
            1: d_8e1 = v[7:0];
            2: d_8o1 = v[7:0];
            default: d_7n2 = v[6:0];
        endcase
    endtask

    // One handshake, then sample every bit centre and time the return of ready
    task automatic run_frame(input int idx, input logic [8:0] word, input logic [15:0] frame,
                             input int nbits, input int len, input string name);
        logic [15:0] got;
        logic [15:0] mask;
        int          rdy_m;
        @(negedge clk);
        set_data(idx, word);
        valid_w[idx] = 1'b1;
        @(negedge clk);
        valid_w[idx] = 1'b0;
        check({name, "_busy"}, 32'(busy_w[idx]), 32'd1);
        got   = '0;
        rdy_m = -1;
        for (int m = 1; m <= len + 5 && rdy_m < 0; m++) begin
            @(negedge clk);
            if ((m % DIV) == DIV / 2 && (m / DIV) < nbits) got[m / DIV] = tx_w[idx];
            if (ready_w[idx]) rdy_m = m;
        end
        mask = 16'((32'd1 << nbits) - 1);
        check({name, "_bits"}, 32'(got & mask), 32'(frame));
        check({name, "_len"}, 32'(rdy_m), 32'(len));
    endtask

    initial begin
        logic [15:0] got1;
        logic [15:0] got2;
        int          fall2;
        int          rdy2;
        int          bad;

        checks   = 0;
        failures = 0;

        vecs[0] = '{0, 9'h0D3, 16'({1'b1, 8'hD3, 1'b0}),       10, 100, "8n1_d3"};
        vecs[1] = '{0, 9'h02C, 16'({1'b1, 8'h2C, 1'b0}),       10, 100, "8n1_2c"};
        vecs[2] = '{1, 9'h0D3, 16'({1'b1, 1'b1, 8'hD3, 1'b0}), 11, 110, "8e1_d3"};
        vecs[3] = '{1, 9'h02C, 16'({1'b1, 1'b1, 8'h2C, 1'b0}), 11, 110, "8e1_2c"};
        vecs[4] = '{2, 9'h02C, 16'({1'b1, 1'b0, 8'h2C, 1'b0}), 11, 110, "8o1_2c"};
        vecs[5] = '{2, 9'h0D3, 16'({1'b1, 1'b0, 8'hD3, 1'b0}), 11, 110, "8o1_d3"};
        vecs[6] = '{2, 9'h000, 16'({1'b1, 1'b1, 8'h00, 1'b0}), 11, 110, "8o1_00"};
        vecs[7] = '{3, 9'h055, 16'({2'b11, 7'h55, 1'b0}),      10, 100, "7n2_55"};

        // Reset held three cycles with valid asserted on every instance
        rst     = 1'b1;
        valid_w = 4'hF;
        d_8n1   = 8'hD3;
        d_8e1   = 8'hD3;
        d_8o1   = 8'hD3;
        d_7n2   = 7'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_tx", 32'(tx_w), 32'hF);
            check("rst_ready", 32'(ready_w), 32'hF);
            check("rst_busy", 32'(busy_w), 32'h0);
        end
        rst     = 1'b0;
        valid_w = 4'h0;
        @(negedge clk);
        check("post_rst_tx", 32'(tx_w), 32'hF);
        check("post_rst_ready", 32'(ready_w), 32'hF);
        check("post_rst_busy", 32'(busy_w), 32'h0);

        for (int v = 0; v < 8; v++) begin
            run_frame(vecs[v].idx, vecs[v].word, vecs[v].frame, vecs[v].nbits,
                      vecs[v].len, vecs[v].name);
        end

        // Back-to-back with valid held: second word only presented just before its handshake
        @(negedge clk);
        set_data(0, 9'h0D3);
        valid_w[0] = 1'b1;
        @(negedge clk);
        set_data(0, 9'h0AA);
        check("b2b_tx_fall", 32'(tx_w[0]), 32'd0);
        got1  = '0;
        got2  = '0;
        fall2 = -1;
        rdy2  = -1;
        for (int m = 1; m <= 215; m++) begin
            @(negedge clk);
            if (m < 100 && (m % DIV) == DIV / 2) got1[m / DIV] = tx_w[0];
            if (m == 100) begin
                check("b2b_ready_gap", 32'(ready_w[0]), 32'd1);
                set_data(0, 9'h02C);
            end
            if (m == 101) begin
                set_data(0, 9'h0AA);
                valid_w[0] = 1'b0;
            end
            if (m >= 100 && fall2 < 0 && tx_w[0] == 1'b0) fall2 = m;
            if (m >= 101 && m < 201 && ((m - 101) % DIV) == DIV / 2) got2[(m - 101) / DIV] = tx_w[0];
            if (m > 101 && rdy2 < 0 && ready_w[0]) rdy2 = m;
        end
        check("b2b_first_bits", 32'(got1 & 16'h03FF), 32'({1'b1, 8'hD3, 1'b0}));
        check("b2b_second_start", 32'(fall2), 32'd101);
        check("b2b_second_bits", 32'(got2 & 16'h03FF), 32'({1'b1, 8'h2C, 1'b0}));
        check("b2b_second_len", 32'(rdy2), 32'd201);

        // Reset during data bit 3 of 8'hFF aborts the frame cleanly
        @(negedge clk);
        set_data(0, 9'h0FF);
        valid_w[0] = 1'b1;
        @(negedge clk);
        valid_w[0] = 1'b0;
        repeat (44) @(negedge clk);
        check("mid_busy_before", 32'(busy_w[0]), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", 32'(tx_w[0]), 32'd1);
        check("mid_rst_ready", 32'(ready_w[0]), 32'd1);
        check("mid_rst_busy", 32'(busy_w[0]), 32'd0);
        rst = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (!tx_w[0] || !ready_w[0] || busy_w[0]) bad++;
        end
        check("mid_rst_quiet", 32'(bad), 32'd0);
        run_frame(0, 9'h0D3, 16'({1'b1, 8'hD3, 1'b0}), 10, 100, "post_mid_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
